// File: rtl/match_pkg.sv
// Shared defaults and types for the match stage: table geometry, FSM state
// encoding and the layout of one match table entry.
package match_pkg;

    localparam int DEF_KEY_W   = 32;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_ACT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESULT = 2'd2
    } state_e;

    typedef struct packed {
        logic                 en;
        logic [DEF_KEY_W-1:0] key;
        logic [DEF_ACT_W-1:0] action;
    } entry_t;

endpackage

// File: rtl/match_if.sv
// Key handshake from the parser and result handshake to the action stage.
// The match stage sits on the slave modport.
interface match_if #(
    parameter int KEY_W = match_pkg::DEF_KEY_W,
    parameter int ACT_W = match_pkg::DEF_ACT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [KEY_W-1:0] in_key;
    logic [15:0]      in_pkt_id;

    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_pkt_id;
    logic             out_hit;
    logic [ACT_W-1:0] out_action_idx;

    modport master (
        output in_valid, in_key, in_pkt_id, out_ready,
        input  in_ready, out_valid, out_pkt_id, out_hit, out_action_idx
    );

    modport slave (
        input  in_valid, in_key, in_pkt_id, out_ready,
        output in_ready, out_valid, out_pkt_id, out_hit, out_action_idx
    );
endinterface

// File: rtl/match_table.sv
// Match table storage: one write port from the register block and one
// combinational indexed read used by the scanning FSM.
module match_table
    import match_pkg::*;
#(
    parameter  int KEY_W   = DEF_KEY_W,
    parameter  int ENTRIES = DEF_ENTRIES,
    parameter  int ACT_W   = DEF_ACT_W,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [ACT_W-1:0] cfg_action,
    input  logic             cfg_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_en,
    output logic [KEY_W-1:0] rd_key,
    output logic [ACT_W-1:0] rd_action
);

    logic [ENTRIES-1:0] en_q;
    logic [KEY_W-1:0]   key_q    [ENTRIES];
    logic [ACT_W-1:0]   action_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
        end else if (cfg_we) begin
            en_q[cfg_addr] <= cfg_en;
        end
    end

    // NOTE: key/action storage has no reset; a cleared enable bit already
    // hides stale contents, and leaving it out keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            key_q[cfg_addr]    <= cfg_key;
            action_q[cfg_addr] <= cfg_action;
        end
    end

    // Reads see pre-edge contents, so a compare racing a write uses old data.
    assign rd_en     = en_q[rd_idx];
    assign rd_key    = key_q[rd_idx];
    assign rd_action = action_q[rd_idx];

endmodule

// File: rtl/match_stage.sv
// Sequential exact-match lookup: scans the table one entry per cycle, lowest
// matching index wins, and holds the result until the action stage takes it.
module match_stage
    import match_pkg::*;
#(
    parameter  int KEY_W   = DEF_KEY_W,
    parameter  int ENTRIES = DEF_ENTRIES,
    parameter  int ACT_W   = DEF_ACT_W,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    match_if.slave           bus,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [ACT_W-1:0] cfg_action,
    input  logic             cfg_en,
    input  logic [ACT_W-1:0] def_action,
    input  logic             cnt_clr,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             out_hit_q, out_hit_d;
    logic [ACT_W-1:0] out_action_q, out_action_d;
    logic [15:0]      out_pkt_q, out_pkt_d;
    logic [31:0]      hit_cnt_q, hit_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;

    logic             rd_en;
    logic [KEY_W-1:0] rd_key;
    logic [ACT_W-1:0] rd_action;
    logic             out_hs;

    match_table #(
        .KEY_W   (KEY_W),
        .ENTRIES (ENTRIES),
        .ACT_W   (ACT_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_key    (cfg_key),
        .cfg_action (cfg_action),
        .cfg_en     (cfg_en),
        .rd_idx     (idx_q),
        .rd_en      (rd_en),
        .rd_key     (rd_key),
        .rd_action  (rd_action)
    );

    assign bus.in_ready       = (state_q == IDLE);
    assign bus.out_valid      = (state_q == RESULT);
    assign bus.out_hit        = out_hit_q;
    assign bus.out_action_idx = out_action_q;
    assign bus.out_pkt_id     = out_pkt_q;
    assign out_hs             = bus.out_valid && bus.out_ready;

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        key_d        = key_q;
        pkt_d        = pkt_q;
        out_hit_d    = out_hit_q;
        out_action_d = out_action_q;
        out_pkt_d    = out_pkt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    key_d   = bus.in_key;
                    pkt_d   = bus.in_pkt_id;
                    idx_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (rd_en && (rd_key == key_q)) begin
                    out_hit_d    = 1'b1;
                    out_action_d = rd_action;
                    out_pkt_d    = pkt_q;
                    state_d      = RESULT;
                end else if (idx_q == LAST_IDX) begin
                    out_hit_d    = 1'b0;
                    out_action_d = def_action;
                    out_pkt_d    = pkt_q;
                    state_d      = RESULT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESULT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear has priority over a same-cycle increment; both counters saturate.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (out_hs) begin
            if (out_hit_q && (hit_cnt_q != '1)) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!out_hit_q && (miss_cnt_q != '1)) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            key_q        <= '0;
            pkt_q        <= '0;
            out_hit_q    <= 1'b0;
            out_action_q <= '0;
            out_pkt_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            key_q        <= key_d;
            pkt_q        <= pkt_d;
            out_hit_q    <= out_hit_d;
            out_action_q <= out_action_d;
            out_pkt_q    <= out_pkt_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_match_stage.sv
// Directed bench for match_stage: latency, priority, miss path, back-pressure,
// scan/write races, reset abandonment and counter clear.
module tb_match_stage;
    import match_pkg::*;

    localparam int KEY_W   = 32;
    localparam int ENTRIES = 16;
    localparam int ACT_W   = 8;
    localparam int IDX_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [KEY_W-1:0] cfg_key;
    logic [ACT_W-1:0] cfg_action;
    logic             cfg_en;
    logic [ACT_W-1:0] def_action;
    logic             cnt_clr;
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always #5 clk = ~clk;

    match_if #(.KEY_W(KEY_W), .ACT_W(ACT_W)) bus ();

    match_stage #(
        .KEY_W   (KEY_W),
        .ENTRIES (ENTRIES),
        .ACT_W   (ACT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_key    (cfg_key),
        .cfg_action (cfg_action),
        .cfg_en     (cfg_en),
        .def_action (def_action),
        .cnt_clr    (cnt_clr),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_entry(input int idx, input entry_t e);
        cfg_we     = 1'b1;
        cfg_addr   = IDX_W'(idx);
        cfg_en     = e.en;
        cfg_key    = e.key;
        cfg_action = e.action;
        tick();
        cfg_we     = 1'b0;
    endtask

    // Accept happens at the edge ending cycle T; afterwards we sit in T+1.
    task automatic start(input logic [KEY_W-1:0] key, input logic [15:0] pkt);
        check("in_ready_before_accept", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_key    = key;
        bus.in_pkt_id = pkt;
        tick();
        bus.in_valid  = 1'b0;
        acc_cyc       = cyc;
    endtask

    task automatic expect_result(input string tag, input int lat, input logic hit,
                                 input logic [ACT_W-1:0] act, input logic [15:0] pkt);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_latency"}, 64'(cyc - acc_cyc + 1), 64'(lat));
        check({tag, "_hit"}, bus.out_hit, hit);
        check({tag, "_action"}, bus.out_action_idx, act);
        check({tag, "_pkt"}, bus.out_pkt_id, pkt);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready_after_hs", bus.in_ready, 1);
    endtask

    initial begin
        logic seen;
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_addr      = '0;
        cfg_key       = '0;
        cfg_action    = '0;
        cfg_en        = 1'b0;
        def_action    = 8'h7F;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_key    = '0;
        bus.in_pkt_id = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_hit", bus.out_hit, 0);
        check("rst_out_action", bus.out_action_idx, 0);
        check("rst_out_pkt", bus.out_pkt_id, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        // Empty table: full scan then default action.
        start(32'h0102_0304, 16'h0001);
        expect_result("miss_empty", 17, 1'b0, 8'h7F, 16'h0001);
        handshake();
        check("miss_cnt_1", miss_cnt, 1);
        check("hit_cnt_0", hit_cnt, 0);

        // Hit at index 3.
        write_entry(3, '{1'b1, 32'hC0A8_0001, 8'h05});
        start(32'hC0A8_0001, 16'h0002);
        expect_result("hit_idx3", 5, 1'b1, 8'h05, 16'h0002);
        handshake();
        check("hit_cnt_1", hit_cnt, 1);

        // Duplicate keys: lowest index wins; then back-pressure for 10 cycles.
        write_entry(2, '{1'b1, 32'h0A00_0001, 8'h11});
        write_entry(7, '{1'b1, 32'h0A00_0001, 8'h22});
        start(32'h0A00_0001, 16'h0003);
        expect_result("lowest_wins", 4, 1'b1, 8'h11, 16'h0003);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", bus.out_valid, 1);
            check("hold_fields", {bus.out_hit, bus.out_action_idx, bus.out_pkt_id},
                  {1'b1, 8'h11, 16'h0003});
            check("hold_in_ready", bus.in_ready, 0);
        end
        handshake();

        // Disabled entry never matches; def_action is taken at the last compare.
        write_entry(5, '{1'b0, 32'h5555_5555, 8'h55});
        start(32'h5555_5555, 16'h0004);
        repeat (5) tick();
        def_action = 8'h3C;
        expect_result("disabled", 17, 1'b0, 8'h3C, 16'h0004);
        handshake();

        // Boundary indices: last and first.
        write_entry(15, '{1'b1, 32'h0F0F_0F0F, 8'hF5});
        start(32'h0F0F_0F0F, 16'h0005);
        expect_result("hit_idx15", 17, 1'b1, 8'hF5, 16'h0005);
        handshake();
        write_entry(0, '{1'b1, 32'hA5A5_A5A5, 8'hA0});
        start(32'hA5A5_A5A5, 16'h0006);
        expect_result("hit_idx0", 2, 1'b1, 8'hA0, 16'h0006);
        handshake();

        // Entry 9 written while the scan is at index 12: miss, then rerun hits.
        start(32'hDEAD_BEEF, 16'h0007);
        repeat (12) tick();
        write_entry(9, '{1'b1, 32'hDEAD_BEEF, 8'h99});
        expect_result("late_write_miss", 17, 1'b0, 8'h3C, 16'h0007);
        handshake();
        start(32'hDEAD_BEEF, 16'h0008);
        expect_result("late_write_rerun", 11, 1'b1, 8'h99, 16'h0008);
        handshake();

        // Write to entry 9 in the same cycle it is compared: old contents used.
        start(32'h1234_5678, 16'h0009);
        repeat (9) tick();
        write_entry(9, '{1'b1, 32'h1234_5678, 8'h77});
        expect_result("same_cycle_write", 17, 1'b0, 8'h3C, 16'h0009);
        handshake();
        check("hit_cnt_5", hit_cnt, 5);
        check("miss_cnt_4", miss_cnt, 4);

        // Reset in the third SEARCH cycle abandons the packet.
        start(32'hC0A8_0001, 16'h000A);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abandon_in_ready", bus.in_ready, 1);
        check("abandon_hit_cnt", hit_cnt, 0);
        check("abandon_miss_cnt", miss_cnt, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | bus.out_valid;
        end
        check("abandon_no_output", seen, 0);
        start(32'hC0A8_0001, 16'h000B);
        expect_result("entries_cleared", 17, 1'b0, 8'h3C, 16'h000B);
        handshake();
        check("post_rst_miss_cnt", miss_cnt, 1);

        // Counter clear beats a simultaneous hit.
        write_entry(3, '{1'b1, 32'hC0A8_0001, 8'h05});
        start(32'hC0A8_0001, 16'h000C);
        expect_result("pre_clr_hit", 5, 1'b1, 8'h05, 16'h000C);
        handshake();
        check("pre_clr_hit_cnt", hit_cnt, 1);
        start(32'hC0A8_0001, 16'h000D);
        expect_result("clr_hit", 5, 1'b1, 8'h05, 16'h000D);
        cnt_clr = 1'b1;
        handshake();
        cnt_clr = 1'b0;
        check("clr_hit_cnt", hit_cnt, 0);
        check("clr_miss_cnt", miss_cnt, 0);
        start(32'hC0A8_0001, 16'h000E);
        expect_result("post_clr_hit", 5, 1'b1, 8'h05, 16'h000E);
        handshake();
        check("post_clr_hit_cnt", hit_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
